// File: rtl/spi_master_pkg.sv
// ---------------------------------------------------------------------------
// spi_master_pkg
// Shared types and constants for the SPI master clock path.
//   spi_state_t        : SCLK generator FSM states (IDLE, RUN)
//   SPI_MODE0..3       : SPI modes encoded as {cpol, cpha}
//   DEFAULT_DIV_W/CNT_W: default divider and bit-counter widths
// ---------------------------------------------------------------------------
package spi_master_pkg;

  localparam int DEFAULT_DIV_W = 8;
  localparam int DEFAULT_CNT_W = 6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } spi_state_t;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_master_div_cnt.sv
// ---------------------------------------------------------------------------
// spi_master_div_cnt
// Half-period divider for SCLK. Holds the active divider value and a free
// counter that wraps on an exact compare, so the full DIV_W range is usable.
//   clk, rstn : clock, asynchronous active-low reset
//   load      : copy load_val into the active divider
//   load_val  : divider value to load (half-period minus one)
//   clr       : clear the counter to zero
//   en        : count this cycle
//   tick      : counter equals the active divider while enabled
// ---------------------------------------------------------------------------
module spi_master_div_cnt
  import spi_master_pkg::*;
#(
  parameter int DIV_W = DEFAULT_DIV_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             clr,
  input  logic             en,
  output logic             tick
);

  localparam logic [DIV_W-1:0] DIV_ONE = 1;

  logic [DIV_W-1:0] div_act;
  logic [DIV_W-1:0] cnt;

  assign tick = en && (cnt == div_act);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_act <= '0;
    end else if (load) begin
      div_act <= load_val;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + DIV_ONE;
    end
  end

endmodule

// File: rtl/spi_master_sclk_gen.sv
// ---------------------------------------------------------------------------
// spi_master_sclk_gen
// SPI serial-clock generator: produces SCLK for CPOL/CPHA modes, per-edge
// lead/trail strobes, sample/shift strobes, a bit count and a done pulse.
//   clk, rstn          : clock, asynchronous active-low reset
//   clk_div/_valid     : divider shadow write (half-period minus one)
//   cfg_cpol, cfg_cpha : mode, latched on an accepted start
//   num_bits           : burst length, latched on an accepted start
//   start, stop        : begin / abort a burst
//   spi_clk            : registered serial clock
//   spi_lead/spi_trail : SCLK leaves / returns to idle level at next edge
//   sample, shift      : capture MISO / advance MOSI this cycle
//   busy, done         : burst in progress / one-cycle completion pulse
//   bit_cnt            : sample strobes issued in current or last burst
// ---------------------------------------------------------------------------
module spi_master_sclk_gen
  import spi_master_pkg::*;
#(
  parameter int DIV_W = DEFAULT_DIV_W,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             clk_div_valid,
  input  logic             cfg_cpol,
  input  logic             cfg_cpha,
  input  logic [CNT_W-1:0] num_bits,
  input  logic             start,
  input  logic             stop,
  output logic             spi_clk,
  output logic             spi_lead,
  output logic             spi_trail,
  output logic             sample,
  output logic             shift,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam logic [CNT_W:0]   EDGE_ONE = 1;
  localparam logic [CNT_W-1:0] BIT_ONE  = 1;

  spi_state_t       state, state_nxt;
  logic [DIV_W-1:0] div_shadow;
  logic [DIV_W-1:0] div_load_val;
  logic             cpol_q, cpha_q;
  logic [CNT_W-1:0] nbits_q;
  logic [CNT_W:0]   edge_cnt;
  logic [CNT_W:0]   edge_last;
  logic             accept;
  logic             run;
  logic             tick;
  logic             div_en;
  logic             div_clr;
  logic             last_trail;

  assign run    = (state == RUN);
  assign accept = (state == IDLE) && start && !stop && (num_bits != '0);
  assign busy   = run;

  // A same-cycle divider write bypasses the shadow so it takes effect now.
  assign div_load_val = clk_div_valid ? clk_div : div_shadow;

  // Edge numbers are zero-based here: final trailing edge is 2*num_bits-1.
  assign edge_last = {nbits_q, 1'b0} - EDGE_ONE;

  // stop suppresses the tick so no strobe can fire in an abort cycle.
  assign div_en  = run && !stop;
  assign div_clr = accept || (run && (stop || last_trail));

  spi_master_div_cnt #(
    .DIV_W (DIV_W)
  ) u_div_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .load     (accept),
    .load_val (div_load_val),
    .clr      (div_clr),
    .en       (div_en),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (stop || last_trail) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    spi_lead   = 1'b0;
    spi_trail  = 1'b0;
    sample     = 1'b0;
    shift      = 1'b0;
    last_trail = 1'b0;
    if (tick) begin
      if (spi_clk == cpol_q) spi_lead  = 1'b1;
      else                   spi_trail = 1'b1;
    end
    last_trail = spi_trail && (edge_cnt == edge_last);
    if (cpha_q) begin
      shift  = spi_lead;
      sample = spi_trail;
    end else begin
      sample = spi_lead;
      // No further data follows the last trailing edge in mode 0/2.
      shift  = spi_trail && !last_trail;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_shadow <= '0;
    end else if (clk_div_valid) begin
      div_shadow <= clk_div;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      nbits_q <= '0;
    end else if (accept) begin
      cpol_q  <= cfg_cpol;
      cpha_q  <= cfg_cpha;
      nbits_q <= num_bits;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      spi_clk <= 1'b0;
    end else if (accept) begin
      spi_clk <= cfg_cpol;
    end else if (!run || stop || last_trail) begin
      spi_clk <= cpol_q;
    end else if (tick) begin
      spi_clk <= ~spi_clk;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      edge_cnt <= '0;
    end else if (div_clr) begin
      edge_cnt <= '0;
    end else if (tick) begin
      edge_cnt <= edge_cnt + EDGE_ONE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt <= '0;
    end else if (accept) begin
      bit_cnt <= '0;
    end else if (sample) begin
      bit_cnt <= bit_cnt + BIT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      done <= 1'b0;
    end else begin
      done <= last_trail;
    end
  end

endmodule

// File: tb/tb_spi_master_sclk_gen.sv
module tb_spi_master_sclk_gen;

  localparam int DIV_W = 8;
  localparam int CNT_W = 6;

  localparam int C_SAMP       = 0;
  localparam int C_SAMP_LEAD  = 1;
  localparam int C_SHIFT      = 2;
  localparam int C_SHIFT_LEAD = 3;
  localparam int C_LEAD       = 4;
  localparam int C_TRAIL      = 5;
  localparam int C_DONE       = 6;
  localparam int C_BUSY       = 7;
  localparam int C_RISE       = 8;
  localparam int C_FALL       = 9;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [DIV_W-1:0] clk_div = '0;
  logic             clk_div_valid = 1'b0;
  logic             cfg_cpol = 1'b0;
  logic             cfg_cpha = 1'b0;
  logic [CNT_W-1:0] num_bits = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             spi_clk, spi_lead, spi_trail, sample, shift, busy, done;
  logic [CNT_W-1:0] bit_cnt;

  int   cnt [10];
  int   base[10];
  int   cyc = 0;
  int   last_rise = 0;
  int   prev_rise = 0;
  logic prev_sclk = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  spi_master_sclk_gen #(
    .DIV_W (DIV_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .clk_div       (clk_div),
    .clk_div_valid (clk_div_valid),
    .cfg_cpol      (cfg_cpol),
    .cfg_cpha      (cfg_cpha),
    .num_bits      (num_bits),
    .start         (start),
    .stop          (stop),
    .spi_clk       (spi_clk),
    .spi_lead      (spi_lead),
    .spi_trail     (spi_trail),
    .sample        (sample),
    .shift         (shift),
    .busy          (busy),
    .done          (done),
    .bit_cnt       (bit_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    cnt[C_SAMP]       <= cnt[C_SAMP]       + int'(sample);
    cnt[C_SAMP_LEAD]  <= cnt[C_SAMP_LEAD]  + int'(sample && spi_lead);
    cnt[C_SHIFT]      <= cnt[C_SHIFT]      + int'(shift);
    cnt[C_SHIFT_LEAD] <= cnt[C_SHIFT_LEAD] + int'(shift && spi_lead);
    cnt[C_LEAD]       <= cnt[C_LEAD]       + int'(spi_lead);
    cnt[C_TRAIL]      <= cnt[C_TRAIL]      + int'(spi_trail);
    cnt[C_DONE]       <= cnt[C_DONE]       + int'(done);
    cnt[C_BUSY]       <= cnt[C_BUSY]       + int'(busy);
    cnt[C_FALL]       <= cnt[C_FALL]       + int'(!spi_clk && prev_sclk);
    if (spi_clk && !prev_sclk) begin
      cnt[C_RISE] <= cnt[C_RISE] + 1;
      prev_rise   <= last_rise;
      last_rise   <= cyc;
    end
    prev_sclk <= spi_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic int delta(input int idx);
    return cnt[idx] - base[idx];
  endfunction

  task automatic snap();
    for (int i = 0; i < 10; i++) base[i] = cnt[i];
  endtask

  task automatic drive_start(input logic v, input logic [DIV_W-1:0] d, input logic cpol,
                             input logic cpha, input logic [CNT_W-1:0] nb);
    @(posedge clk); #1;
    clk_div_valid = v;
    clk_div       = d;
    cfg_cpol      = cpol;
    cfg_cpha      = cpha;
    num_bits      = nb;
    start         = 1'b1;
    @(posedge clk); #1;
    start         = 1'b0;
    clk_div_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk(tag, busy, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    #7;
    chk("rst_sclk", spi_clk, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bitcnt", bit_cnt, 0);
    chk("rst_strobes", {spi_lead, spi_trail, sample, shift}, 0);
    #15 rstn = 1'b1;

    // mode0, div=1, 8 bits
    drive_start(1'b1, 8'd1, 1'b0, 1'b0, 6'd8);
    snap();
    wait_idle("m0_timeout");
    chk("m0_rises", delta(C_RISE), 8);
    chk("m0_period", last_rise - prev_rise, 4);
    chk("m0_samples", delta(C_SAMP), 8);
    chk("m0_samp_on_lead", delta(C_SAMP_LEAD), 8);
    chk("m0_shifts", delta(C_SHIFT), 7);
    chk("m0_busy_cycles", delta(C_BUSY), 32);
    chk("m0_done", delta(C_DONE), 1);
    chk("m0_bitcnt", bit_cnt, 8);
    chk("m0_sclk_end", spi_clk, 0);

    // mode3, div=0, 4 bits
    drive_start(1'b1, 8'd0, 1'b1, 1'b1, 6'd4);
    snap();
    chk("m3_idle_level", spi_clk, 1);
    wait_idle("m3_timeout");
    chk("m3_period", last_rise - prev_rise, 2);
    chk("m3_shifts", delta(C_SHIFT), 4);
    chk("m3_shift_on_lead", delta(C_SHIFT_LEAD), 4);
    chk("m3_falls", delta(C_FALL), 4);
    chk("m3_samples", delta(C_SAMP), 4);
    chk("m3_samp_on_trail", delta(C_SAMP) - delta(C_SAMP_LEAD), 4);
    chk("m3_edges", delta(C_LEAD) + delta(C_TRAIL), 8);
    chk("m3_done", delta(C_DONE), 1);
    chk("m3_sclk_end", spi_clk, 1);
    chk("m3_bitcnt", bit_cnt, 4);

    // divider shadowing and start-while-busy
    drive_start(1'b1, 8'd1, 1'b0, 1'b0, 6'd4);
    snap();
    repeat (3) @(posedge clk);
    drive_start(1'b0, 8'd0, 1'b1, 1'b1, 6'd8);
    @(posedge clk); #1;
    clk_div = 8'd3; clk_div_valid = 1'b1;
    @(posedge clk); #1;
    clk_div_valid = 1'b0;
    wait_idle("sh_timeout");
    chk("sh_period_kept", last_rise - prev_rise, 4);
    chk("busy_start_edges", delta(C_LEAD) + delta(C_TRAIL), 8);
    chk("busy_start_bitcnt", bit_cnt, 4);
    chk("busy_start_done", delta(C_DONE), 1);
    drive_start(1'b0, 8'd0, 1'b0, 1'b0, 6'd2);
    snap();
    wait_idle("sh2_timeout");
    chk("sh_period_new", last_rise - prev_rise, 8);
    drive_start(1'b1, 8'd5, 1'b0, 1'b0, 6'd2);
    snap();
    wait_idle("sh3_timeout");
    chk("sh_period_bypass", last_rise - prev_rise, 12);

    // num_bits == 0 is ignored
    snap();
    drive_start(1'b0, 8'd0, 1'b0, 1'b0, 6'd0);
    chk("nb0_busy", busy, 0);
    repeat (5) @(negedge clk);
    chk("nb0_busy_cycles", delta(C_BUSY), 0);
    chk("nb0_done", delta(C_DONE), 0);

    // abort after the 3rd sample
    drive_start(1'b1, 8'd2, 1'b0, 1'b0, 6'd16);
    snap();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (delta(C_SAMP) >= 3) break;
    end
    chk("stop_wait", delta(C_SAMP), 3);
    #1 stop = 1'b1;
    @(negedge clk);
    chk("stop_strobes", {spi_lead, spi_trail, sample, shift}, 0);
    @(posedge clk); #1;
    stop = 1'b0;
    chk("stop_sclk", spi_clk, 0);
    chk("stop_busy", busy, 0);
    chk("stop_bitcnt", bit_cnt, 3);
    repeat (6) @(negedge clk);
    chk("stop_no_done", delta(C_DONE), 0);

    // async reset mid-burst
    drive_start(1'b1, 8'd1, 1'b0, 1'b0, 6'd8);
    snap();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (delta(C_LEAD) + delta(C_TRAIL) >= 5) break;
    end
    chk("rr_wait", delta(C_LEAD) + delta(C_TRAIL), 5);
    #1 rstn = 1'b0;
    #1;
    chk("rr_sclk", spi_clk, 0);
    chk("rr_busy", busy, 0);
    chk("rr_done", done, 0);
    chk("rr_bitcnt", bit_cnt, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    drive_start(1'b0, 8'd0, 1'b0, 1'b0, 6'd2);
    snap();
    wait_idle("rr2_timeout");
    chk("rr_period_div0", last_rise - prev_rise, 2);
    chk("rr_done_after", delta(C_DONE), 1);
    chk("rr_bitcnt_after", bit_cnt, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_master_sclk_gen.md
Name: spi_master_sclk_gen

Overview:
Parametrised SPI serial-clock generator for the APB-to-SPI master. It produces SCLK with configurable divider width, selectable CPOL/CPHA mode and a burst length in bits. It also emits per-edge sample/shift strobes, a bit count and a done pulse, so the shift register and controller FSM carry no clock-edge logic. Divider changes are shadowed, so SCLK never glitches mid-transfer.

Parameters:
DIV_W, 8, width of the clock-divider value; SCLK half-period = clk_div+1 clk cycles
CNT_W, 6, width of num_bits/bit_cnt; maximum burst length is 2^CNT_W-1 bits

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
clk_div  in  DIV_W  half-period minus one
clk_div_valid  in  1  load clk_div into the shadow register
cfg_cpol  in  1  SCLK idle level; sampled on an accepted start
cfg_cpha  in  1  0: sample leading/shift trailing; 1: shift leading/sample trailing; sampled on an accepted start
num_bits  in  CNT_W  bits in the burst; sampled on an accepted start
start  in  1  one-cycle request to begin a burst
stop  in  1  abort the current burst
spi_clk  out  1  serial clock (registered)
spi_lead  out  1  strobe: spi_clk toggles leaving idle level at next clk edge
spi_trail  out  1  strobe: spi_clk toggles back to idle level at next clk edge
sample  out  1  strobe: capture MISO this cycle
shift  out  1  strobe: advance MOSI this cycle
busy  out  1  burst in progress
done  out  1  one-cycle pulse on normal completion
bit_cnt  out  CNT_W  sample strobes issued in current/last burst

Behaviour:
- Reset (asynchronous, any state): state IDLE; spi_clk=0; div shadow=0; div active=0; cpol/cpha latches=0; counters=0; busy=0; done=0; bit_cnt=0. All strobes are 0 because they decode from state IDLE.
- Divider shadow: clk_div_valid writes the shadow on any cycle. The active divider is copied from the shadow only on an accepted start, so transfers in flight are unaffected. If clk_div_valid and start occur in the same cycle, the new clk_div is used (bypass).
- FSM states:
  - IDLE: spi_clk = latched cpol.
  - RUN.
- Transition IDLE->RUN on start && !stop && num_bits!=0. This is an accepted start.
  - It latches cpol, cpha, num_bits and the divider.
  - It clears the div counter, edge counter and bit_cnt.
  - busy=1 from the next cycle.
- Any other start in IDLE is ignored. This covers num_bits==0 and start with stop in the same cycle. Start in RUN is also ignored.
- RUN: the div counter increments each clk.
  - When it equals the active divider, an edge strobe is asserted combinationally in that cycle. The counter then wraps to 0, spi_clk toggles at the next edge and the edge counter increments.
  - The strobe is spi_lead if spi_clk==cpol, else spi_trail.
- Strobe decode:
  - cpha=0: sample=spi_lead; shift=spi_trail, except on the final trailing edge.
  - cpha=1: shift=spi_lead; sample=spi_trail.
- bit_cnt increments on every sample.
- Latency: the first edge strobe occurs in cycle start+1+div, and spi_clk first toggles at the end of that cycle.
- Completion: the final edge is trailing edge number 2*num_bits.
  - At the end of that cycle: state->IDLE, spi_clk returns to cpol, busy->0, done->1 for exactly one cycle.
  - bit_cnt then holds num_bits until the next accepted start.
- stop in RUN has priority over any edge in that cycle: no strobes are asserted.
  - Next edge: state->IDLE, spi_clk forced to cpol, counters cleared except bit_cnt (held), busy->0.
  - No done pulse.
- stop in IDLE has no effect.
- clk_div=0 gives spi_clk = clk/2. The max divider gives a half-period of 2^DIV_W cycles. Counter compare is exact, with no overflow.
- Edge counter width is CNT_W+1 bits, so 2*(2^CNT_W-1) edges fit.

Decomposition:
- Package spi_master_pkg holds:
  - the state typedef (IDLE, RUN);
  - the mode constants SPI_MODE0..3 as {cpol,cpha};
  - localparam defaults for DIV_W/CNT_W.
- One sub-module, spi_master_div_cnt: divider counter with load/clear/enable, outputting a terminal-count tick. The top holds the FSM, edge/bit counters and strobe decode.

Test Plan:
- div=1, mode0, num_bits=8, start -> spi_clk period 4 clk with 8 rising edges; 8 sample on lead; 7 shift; busy for 32 cycles; done exactly once; bit_cnt=8; spi_clk ends at 0.
- div=0, mode3 (cpol=1,cpha=1), num_bits=4 -> spi_clk idles 1, period 2 clk; 4 shift on falling edges; 4 sample on rising edges; done after 8 edges.
- mode0, div=2, num_bits=16, stop asserted the cycle after the 3rd sample -> no strobe in the stop cycle; spi_clk=0 next cycle; busy=0; no done; bit_cnt=3.
- During a burst with div=1, clk_div_valid with clk_div=3 -> current burst keeps period 4. The next start gives period 8. Same-cycle valid+start with clk_div=5 -> period 12.
- Start while busy -> ignored, edge count unchanged. start with num_bits=0 in IDLE -> busy stays 0, no done.
- rstn low mid-RUN (after 5 edges) -> immediately spi_clk=0, busy=0, done=0, bit_cnt=0. After release the shadow divider is 0, and a new start runs at clk/2.
